// File: rtl/v_hier_subsub_arb.sv
// Round-robin arbiter sharing one 1-bit v_hier_subsub lane among NREQ requesters,
// with a per-grant burst limit and a registered, strobed return path.
module v_hier_subsub_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAXBURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] a_in,
  output logic [NREQ-1:0] gnt,
  output logic            lane_a,
  input  logic            lane_q,
  output logic [NREQ-1:0] q_out,
  output logic [NREQ-1:0] q_vld,
  output logic            busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   g_q, g_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_d, q_out_d, q_vld_d;
  logic [PW-1:0]   g_nxt;
  logic [NREQ-1:0] others;
  logic [PW:0]     pick_idle, pick_rot;

  // First requester at or after base (wrapping); MSB flags that one was found.
  function automatic logic [PW:0] pick_f(input logic [NREQ-1:0] r, input logic [PW-1:0] base);
    logic [PW:0] res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(base) + k) % NREQ;
      if (!res[PW] && r[idx[PW-1:0]]) res = {1'b1, idx[PW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot_f(input logic [PW-1:0] i);
    logic [NREQ-1:0] o;
    o    = '0;
    o[i] = 1'b1;
    return o;
  endfunction

  // Lane drive and busy flag are decoded straight from the registered grant.
  assign lane_a = |(gnt & req & a_in);
  assign busy   = |gnt;

  // Requester after the current grant, wrapping at NREQ-1.
  assign g_nxt     = (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
  assign others    = req & ~gnt;
  assign pick_idle = pick_f(req, ptr_q);
  assign pick_rot  = pick_f(others, g_nxt);

  // Next-state, grant, burst counter and return-path decode.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt;
    q_out_d = q_out;
    q_vld_d = '0;
    case (state_q)
      IDLE: begin
        if (pick_idle[PW]) begin
          state_d = GRANT;
          g_d     = pick_idle[PW-1:0];
          gnt_d   = onehot_f(pick_idle[PW-1:0]);
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (!req[g_q]) begin
          // Release: no transfer this cycle, hand over or fall idle.
          ptr_d = g_nxt;
          if (pick_rot[PW]) begin
            g_d   = pick_rot[PW-1:0];
            gnt_d = onehot_f(pick_rot[PW-1:0]);
            cnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          // Transfer cycle: capture the lane result for the granted requester.
          q_out_d[g_q] = lane_q;
          q_vld_d[g_q] = 1'b1;
          if (cnt_q < CW'(MAXBURST)) begin
            cnt_d = cnt_q + CW'(1);
          end else if (pick_rot[PW]) begin
            ptr_d = g_nxt;
            g_d   = pick_rot[PW-1:0];
            gnt_d = onehot_f(pick_rot[PW-1:0]);
            cnt_d = CW'(1);
          end else begin
            cnt_d = CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      q_out   <= '0;
      q_vld   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      q_out   <= q_out_d;
      q_vld   <= q_vld_d;
    end
  end

endmodule

// File: tb/tb_v_hier_subsub_arb.sv
// Directed bench for v_hier_subsub_arb; the lane is modelled as q = a.
module tb_v_hier_subsub_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] a_in;
  logic [3:0] gnt;
  logic       lane_a;
  logic       lane_q;
  logic [3:0] q_out;
  logic [3:0] q_vld;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  v_hier_subsub_arb #(.NREQ(4), .MAXBURST(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a_in  (a_in),
    .gnt   (gnt),
    .lane_a(lane_a),
    .lane_q(lane_q),
    .q_out (q_out),
    .q_vld (q_vld),
    .busy  (busy)
  );

  assign lane_q = lane_a;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    a_in = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int         vld_cnt;
    logic [3:0] exp_g;
    logic [3:0] prev_g;

    // 1. Reset holds everything low even with all requests up
    rst  = 1'b1;
    req  = 4'b1111;
    a_in = 4'b0000;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_qvld", 32'(q_vld), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_qout", 32'(q_out), 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    chk("rst_first_busy", 32'(busy), 32'h1);

    // 2. Single requester 2, data 1,0,1
    do_reset();
    req  = 4'b0100;
    a_in = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_qvld0", 32'(q_vld), 32'h0);
    #1;
    chk("single_lane1", 32'(lane_a), 32'h1);
    tick();
    chk("single_qvld1", 32'(q_vld), 32'h4);
    chk("single_qout1", 32'(q_out), 32'h4);
    a_in = 4'b0000;
    #1;
    chk("single_lane0", 32'(lane_a), 32'h0);
    tick();
    chk("single_qvld2", 32'(q_vld), 32'h4);
    chk("single_qout2", 32'(q_out), 32'h0);
    a_in = 4'b0100;
    tick();
    chk("single_qvld3", 32'(q_vld), 32'h4);
    chk("single_qout3", 32'(q_out), 32'h4);
    req = 4'b0000;
    tick();
    chk("single_rel_gnt", 32'(gnt), 32'h0);
    chk("single_rel_qvld", 32'(q_vld), 32'h0);
    chk("single_rel_busy", 32'(busy), 32'h0);
    chk("single_rel_qout", 32'(q_out), 32'h4);

    // 3. Burst limit with two requesters: 0001 x4, 0010 x4, 0001 x4
    do_reset();
    req    = 4'b0011;
    a_in   = 4'b0011;
    prev_g = 4'b0000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_g = ((((k - 1) / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
      chk($sformatf("burst_gnt_%0d", k), 32'(gnt), 32'(exp_g));
      chk($sformatf("burst_qvld_%0d", k), 32'(q_vld), 32'(prev_g));
      prev_g = exp_g;
    end

    // 4. Grant on 3, then 3 drops while 0 and 1 wait: wrap to 0, no strobe
    do_reset();
    req  = 4'b1000;
    a_in = 4'b1000;
    tick();
    chk("wrap_gnt3", 32'(gnt), 32'h8);
    tick();
    chk("wrap_qvld3", 32'(q_vld), 32'h8);
    chk("wrap_qout3", 32'(q_out), 32'h8);
    req = 4'b0011;
    tick();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    chk("wrap_qvld_drop", 32'(q_vld), 32'h0);

    // 5. Lone requester 3 streams past the burst limit
    do_reset();
    req     = 4'b1000;
    a_in    = 4'b0000;
    vld_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("stream_gnt_%0d", k), 32'(gnt), 32'h8);
      if (q_vld[3]) vld_cnt++;
    end
    chk("stream_vld_count", 32'(vld_cnt), 32'd9);

    // 6. Async reset mid-burst after a rotation moved ptr to 1
    do_reset();
    req  = 4'b0011;
    a_in = 4'b0011;
    for (int k = 1; k <= 6; k++) tick();
    chk("mid_gnt_before", 32'(gnt), 32'h2);
    chk("mid_qvld_before", 32'(q_vld), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_gnt_async", 32'(gnt), 32'h0);
    chk("mid_qvld_async", 32'(q_vld), 32'h0);
    chk("mid_busy_async", 32'(busy), 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_g = (k <= 4) ? 4'b0001 : 4'b0010;
      chk($sformatf("mid_restart_gnt_%0d", k), 32'(gnt), 32'(exp_g));
      if (k == 1) chk("mid_restart_qvld", 32'(q_vld), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
